// File: rtl/microwave_ctrl.sv
// Microwave oven controller: keypad digit entry, mm:ss timer load/enable
// sequencing, magnetron drive and door/stop interlocks.
module microwave_ctrl (
   input  logic       clk,
   input  logic       clear,
   input  logic       tick,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic [3:0] so_data,
   output logic [3:0] st_data,
   output logic [3:0] min_data,
   output logic       timer_load,
   output logic       timer_enable,
   output logic       timer_clearn,
   output logic       mag_on,
   output logic       done,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      LOAD  = 3'd2,
      COOK  = 3'd3,
      PAUSE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] so_q, st_q, min_q;
   logic       clearn_q;
   logic       key_ok;
   logic       dig_shift, dig_zero, clr_pulse;
   logic       cook_pause;

   assign key_ok     = key_valid && (key_digit <= 4'd9);
   assign cook_pause = !timer_zero && (stop || !door_closed);

   always_comb begin
      state_d   = state_q;
      dig_shift = 1'b0;
      dig_zero  = 1'b0;
      clr_pulse = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (key_ok) begin
               dig_shift = 1'b1;
               state_d   = ENTRY;
            end
         end
         ENTRY: begin
            if (stop) begin
               dig_zero = 1'b1;
               state_d  = IDLE;
            end else if (start && door_closed && (st_q <= 4'd5) &&
                         ({min_q, st_q, so_q} != 12'h000)) begin
               state_d = LOAD;
            end else if (key_ok) begin
               dig_shift = 1'b1;
            end
         end
         LOAD:  state_d = COOK;
         COOK: begin
            if (timer_zero)      state_d = DONE;
            else if (cook_pause) state_d = PAUSE;
         end
         PAUSE: begin
            if (stop) begin
               dig_zero  = 1'b1;
               clr_pulse = 1'b1;
               state_d   = IDLE;
            end else if (start && door_closed) begin
               state_d = COOK;
            end
         end
         DONE: begin
            if (stop || !door_closed || key_ok) begin
               dig_zero = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         so_q  <= '0;
         st_q  <= '0;
         min_q <= '0;
      end else if (dig_zero) begin
         so_q  <= '0;
         st_q  <= '0;
         min_q <= '0;
      end else if (dig_shift) begin
         min_q <= st_q;
         st_q  <= so_q;
         so_q  <= key_digit;
      end
   end

   // Held low through clear and for the first IDLE cycle after a PAUSE cancel.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) clearn_q <= 1'b0;
      else       clearn_q <= !clr_pulse;
   end

   assign so_data      = so_q;
   assign st_data      = st_q;
   assign min_data     = min_q;
   assign state        = state_q;
   assign timer_load   = (state_q == LOAD);
   assign mag_on       = (state_q == COOK);
   assign done         = (state_q == DONE);
   assign timer_enable = (state_q == COOK) && tick && !cook_pause;
   assign timer_clearn = clearn_q;

endmodule
